// File: rtl/multicycle_mem_bridge_if.sv
// Interface: multicycle_mem_bridge_if
// Bundles the core-side request/response signals and the system-bus
// signals of the data-memory bridge.
//   master : the bridge itself (takes core requests, drives the bus)
//   slave  : the environment (ctlpath/datapath plus the bus slave)
// Core side : core_read_enable, core_write_enable, core_data_format,
//             core_address, core_write_data -> bridge;
//             core_read_data, core_done, core_fault, fault_cause <- bridge
// Bus side  : bus_address, bus_write_data, bus_byte_enable,
//             bus_read_enable, bus_write_enable <- bridge;
//             bus_ready, bus_read_data -> bridge
interface multicycle_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      core_read_enable;
    logic                      core_write_enable;
    logic [2:0]                core_data_format;
    logic [ADDR_WIDTH-1:0]     core_address;
    logic [DATA_WIDTH-1:0]     core_write_data;
    logic [DATA_WIDTH-1:0]     core_read_data;
    logic                      core_done;
    logic                      core_fault;
    logic [1:0]                fault_cause;

    logic [ADDR_WIDTH-1:0]     bus_address;
    logic [DATA_WIDTH-1:0]     bus_write_data;
    logic [DATA_WIDTH/8-1:0]   bus_byte_enable;
    logic                      bus_read_enable;
    logic                      bus_write_enable;
    logic                      bus_ready;
    logic [DATA_WIDTH-1:0]     bus_read_data;

    modport master (
        input  core_read_enable, core_write_enable, core_data_format,
               core_address, core_write_data,
        output core_read_data, core_done, core_fault, fault_cause,
        output bus_address, bus_write_data, bus_byte_enable,
               bus_read_enable, bus_write_enable,
        input  bus_ready, bus_read_data
    );

    modport slave (
        output core_read_enable, core_write_enable, core_data_format,
               core_address, core_write_data,
        input  core_read_data, core_done, core_fault, fault_cause,
        input  bus_address, bus_write_data, bus_byte_enable,
               bus_read_enable, bus_write_enable,
        output bus_ready, bus_read_data
    );
endinterface

// File: rtl/multicycle_mem_bridge.sv
// Module: multicycle_mem_bridge
// Data-memory bridge between the multicycle core and the system bus.
// Steers byte lanes, sign/zero-extends loads, checks alignment and format,
// and waits on bus_ready with an optional timeout. Faults are reported to
// the ctlpath as a core_fault pulse alongside core_done plus a held cause.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   mem    : multicycle_mem_bridge_if.master (core request/response + bus)
// Parameters:
//   ADDR_WIDTH     : byte-address width
//   DATA_WIDTH     : bus/data width, 32 or 64
//   TIMEOUT_CYCLES : max ACCESS cycles without bus_ready, 0 disables
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a read or write enable
// ST_ACCESS | bus strobe high, waiting for bus_ready or timeout
// ST_DONE   | core_done (and core_fault if failed) pulse, back to IDLE
module multicycle_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    multicycle_mem_bridge_if.master mem
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(NB);
    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    logic [1:0]            state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [LANE_W-1:0]     req_lane;

    logic [DATA_WIDTH-1:0] core_read_data_q;
    logic                  core_done_q;
    logic                  core_fault_q;
    logic [1:0]            fault_cause_q;
    logic [ADDR_WIDTH-1:0] bus_address_q;
    logic [DATA_WIDTH-1:0] bus_write_data_q;
    logic [NB-1:0]         bus_byte_enable_q;
    logic                  bus_read_enable_q;
    logic                  bus_write_enable_q;

    // ---------------------------------------------------------------
    // Request decode (evaluated on the live core inputs in IDLE)
    // ---------------------------------------------------------------
    logic                  req_any;
    logic [1:0]            size_in;
    logic [LANE_W-1:0]     lane_in;
    logic                  fmt_illegal;
    logic                  addr_misaligned;
    logic [7:0]            size_mask;
    logic [NB-1:0]         be_in;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [ADDR_WIDTH-1:0] addr_aligned;

    always_comb begin
        req_any         = mem.core_read_enable | mem.core_write_enable;
        size_in         = mem.core_data_format[1:0];
        lane_in         = mem.core_address[LANE_W-1:0];
        addr_aligned    = {mem.core_address[ADDR_WIDTH-1:LANE_W], LANE_W'(0)};

        fmt_illegal     = (mem.core_read_enable & mem.core_write_enable)
                        | ((size_in == 2'd3) && (DATA_WIDTH < 64))
                        | (mem.core_write_enable & mem.core_data_format[2]);

        addr_misaligned = 1'b0;
        size_mask       = 8'h01;
        wdata_rep       = {NB{mem.core_write_data[7:0]}};
        case (size_in)
            2'd1: begin
                addr_misaligned = mem.core_address[0];
                size_mask       = 8'h03;
                wdata_rep       = {(NB/2){mem.core_write_data[15:0]}};
            end
            2'd2: begin
                addr_misaligned = |mem.core_address[1:0];
                size_mask       = 8'h0F;
                wdata_rep       = {(NB/4){mem.core_write_data[31:0]}};
            end
            2'd3: begin
                addr_misaligned = |mem.core_address[2:0];
                size_mask       = 8'hFF;
                wdata_rep       = mem.core_write_data;
            end
            default: begin
                addr_misaligned = 1'b0;
                size_mask       = 8'h01;
                wdata_rep       = {NB{mem.core_write_data[7:0]}};
            end
        endcase

        be_in = size_mask[NB-1:0] << lane_in;
    end

    // ---------------------------------------------------------------
    // Load extraction: shift the addressed lane down, then mask and
    // fill the upper bits with the sign bit (or zero for unsigned).
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_shifted;
    logic [DATA_WIDTH-1:0] rd_mask;
    logic                  rd_sign;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        rd_shifted = mem.bus_read_data >> {req_lane, 3'b000};
        case (req_size)
            2'd0: begin
                rd_mask = DATA_WIDTH'(8'hFF);
                rd_sign = rd_shifted[7];
            end
            2'd1: begin
                rd_mask = DATA_WIDTH'(16'hFFFF);
                rd_sign = rd_shifted[15];
            end
            2'd2: begin
                rd_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                rd_sign = rd_shifted[31];
            end
            default: begin
                rd_mask = '1;
                rd_sign = 1'b0;
            end
        endcase
        load_ext = (rd_shifted & rd_mask)
                 | ({DATA_WIDTH{rd_sign & ~req_unsigned}} & ~rd_mask);
    end

    // ---------------------------------------------------------------
    // FSM and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            wait_cnt           <= '0;
            req_write          <= 1'b0;
            req_size           <= 2'd0;
            req_unsigned       <= 1'b0;
            req_lane           <= '0;
            core_read_data_q   <= '0;
            core_done_q        <= 1'b0;
            core_fault_q       <= 1'b0;
            fault_cause_q      <= FC_NONE;
            bus_address_q      <= '0;
            bus_write_data_q   <= '0;
            bus_byte_enable_q  <= '0;
            bus_read_enable_q  <= 1'b0;
            bus_write_enable_q <= 1'b0;
        end else begin
            core_done_q  <= 1'b0;
            core_fault_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        req_write    <= mem.core_write_enable;
                        req_size     <= size_in;
                        req_unsigned <= mem.core_data_format[2];
                        req_lane     <= lane_in;
                        wait_cnt     <= '0;
                        if (fmt_illegal) begin
                            state         <= ST_DONE;
                            core_done_q   <= 1'b1;
                            core_fault_q  <= 1'b1;
                            fault_cause_q <= FC_ILLEGAL;
                        end else if (addr_misaligned) begin
                            state         <= ST_DONE;
                            core_done_q   <= 1'b1;
                            core_fault_q  <= 1'b1;
                            fault_cause_q <= FC_MISALIGN;
                        end else begin
                            state              <= ST_ACCESS;
                            fault_cause_q      <= FC_NONE;
                            bus_address_q      <= addr_aligned;
                            bus_write_data_q   <= wdata_rep;
                            bus_byte_enable_q  <= be_in;
                            bus_read_enable_q  <= mem.core_read_enable;
                            bus_write_enable_q <= mem.core_write_enable;
                        end
                    end
                end
                ST_ACCESS: begin
                    // bus_ready wins over a timeout in the same cycle.
                    if (mem.bus_ready) begin
                        state              <= ST_DONE;
                        core_done_q        <= 1'b1;
                        bus_read_enable_q  <= 1'b0;
                        bus_write_enable_q <= 1'b0;
                        if (!req_write) begin
                            core_read_data_q <= load_ext;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
                        state              <= ST_DONE;
                        core_done_q        <= 1'b1;
                        core_fault_q       <= 1'b1;
                        fault_cause_q      <= FC_TIMEOUT;
                        bus_read_enable_q  <= 1'b0;
                        bus_write_enable_q <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.core_read_data   = core_read_data_q;
    assign mem.core_done        = core_done_q;
    assign mem.core_fault       = core_fault_q;
    assign mem.fault_cause      = fault_cause_q;
    assign mem.bus_address      = bus_address_q;
    assign mem.bus_write_data   = bus_write_data_q;
    assign mem.bus_byte_enable  = bus_byte_enable_q;
    assign mem.bus_read_enable  = bus_read_enable_q;
    assign mem.bus_write_enable = bus_write_enable_q;

endmodule

// File: tb/tb_multicycle_mem_bridge.sv
module tb_multicycle_mem_bridge;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multicycle_mem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b32 ();
    multicycle_mem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) b64 ();

    multicycle_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) u32 (
        .clock (clock),
        .reset (reset),
        .mem   (b32)
    );

    multicycle_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0)) u64 (
        .clock (clock),
        .reset (reset),
        .mem   (b64)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wide;
        bit          re;
        bit          we;
        logic [2:0]  fmt;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        logic [7:0]  be;
        logic [63:0] bwdata;
        logic [63:0] exp_rd;
        int          lat;
        int          strobes;
        bit          fault;
        logic [1:0]  cause;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        b32.core_read_enable = 1'b0; b32.core_write_enable = 1'b0;
        b32.core_data_format = 3'd0; b32.core_address = '0; b32.core_write_data = '0;
        b32.bus_ready = 1'b0; b32.bus_read_data = '0;
        b64.core_read_enable = 1'b0; b64.core_write_enable = 1'b0;
        b64.core_data_format = 3'd0; b64.core_address = '0; b64.core_write_data = '0;
        b64.bus_ready = 1'b0; b64.bus_read_data = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          n, w, sc;
        bit          done_seen, rdy;
        logic        s_re, s_we, s_done, s_fault;
        logic [1:0]  s_cause;
        logic [63:0] s_rd, s_bw;
        logic [31:0] s_addr;
        logic [7:0]  s_be;
        logic [31:0] amask;
        amask = v.wide ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
        if (v.wide) begin
            b64.core_read_enable = v.re; b64.core_write_enable = v.we;
            b64.core_data_format = v.fmt; b64.core_address = v.addr;
            b64.core_write_data = v.wdata; b64.bus_read_data = v.rdata;
        end else begin
            b32.core_read_enable = v.re; b32.core_write_enable = v.we;
            b32.core_data_format = v.fmt; b32.core_address = v.addr;
            b32.core_write_data = v.wdata[31:0]; b32.bus_read_data = v.rdata[31:0];
        end
        n = 0; w = 0; sc = 0; done_seen = 1'b0;
        while (!done_seen && n < 40) begin
            @(negedge clock);
            n++;
            s_re    = v.wide ? b64.bus_read_enable  : b32.bus_read_enable;
            s_we    = v.wide ? b64.bus_write_enable : b32.bus_write_enable;
            s_done  = v.wide ? b64.core_done        : b32.core_done;
            s_fault = v.wide ? b64.core_fault       : b32.core_fault;
            s_cause = v.wide ? b64.fault_cause      : b32.fault_cause;
            s_rd    = v.wide ? b64.core_read_data   : {32'b0, b32.core_read_data};
            s_bw    = v.wide ? b64.bus_write_data   : {32'b0, b32.bus_write_data};
            s_addr  = v.wide ? b64.bus_address      : b32.bus_address;
            s_be    = v.wide ? b64.bus_byte_enable  : {4'b0, b32.bus_byte_enable};
            rdy = 1'b0;
            if (s_re | s_we) begin
                sc++;
                if (sc == 1) begin
                    chk($sformatf("v%0d dir", idx), {s_re, s_we}, {v.re, v.we});
                    chk($sformatf("v%0d be", idx), s_be, v.be);
                    chk($sformatf("v%0d addr", idx), s_addr, v.addr & amask);
                    if (v.we) chk($sformatf("v%0d bus_wdata", idx), s_bw, v.bwdata);
                end
                if (w == v.waits) rdy = 1'b1;
                else w++;
            end
            if (v.wide) b64.bus_ready = rdy; else b32.bus_ready = rdy;
            if (s_done) begin
                done_seen = 1'b1;
                chk($sformatf("v%0d latency", idx), n, v.lat);
                chk($sformatf("v%0d strobes", idx), sc, v.strobes);
                chk($sformatf("v%0d fault", idx), s_fault, v.fault);
                chk($sformatf("v%0d cause", idx), s_cause, v.cause);
                chk($sformatf("v%0d read_data", idx), s_rd, v.exp_rd);
            end
        end
        if (!done_seen) chk($sformatf("v%0d done_timeout", idx), 0, 1);
        idle_inputs();
        @(negedge clock);
        s_done  = v.wide ? b64.core_done   : b32.core_done;
        s_cause = v.wide ? b64.fault_cause : b32.fault_cause;
        chk($sformatf("v%0d done_pulse", idx), s_done, 1'b0);
        chk($sformatf("v%0d cause_hold", idx), s_cause, v.cause);
    endtask

    initial begin
        //          wide re we fmt     addr        wdata           rdata                  waits be     bwdata                 exp_rd                 lat str flt cause
        vecs[0]  = '{0, 1, 0, 3'b010, 32'h100, 64'h0,          64'hDEADBEEF,          0,    8'h0F, 64'h0,                 64'hDEADBEEF,          2,  1,  0, 2'b00};
        vecs[1]  = '{0, 1, 0, 3'b000, 32'h103, 64'h0,          64'h80123456,          0,    8'h08, 64'h0,                 64'hFFFFFF80,          2,  1,  0, 2'b00};
        vecs[2]  = '{0, 1, 0, 3'b100, 32'h103, 64'h0,          64'h80123456,          0,    8'h08, 64'h0,                 64'h00000080,          2,  1,  0, 2'b00};
        vecs[3]  = '{0, 0, 1, 3'b001, 32'h102, 64'h0000ABCD,   64'h0,                 3,    8'h0C, 64'hABCDABCD,          64'h00000080,          5,  4,  0, 2'b00};
        vecs[4]  = '{0, 1, 0, 3'b010, 32'h101, 64'h0,          64'h0,                 0,    8'h00, 64'h0,                 64'h00000080,          1,  0,  1, 2'b01};
        vecs[5]  = '{0, 1, 0, 3'b010, 32'h104, 64'h0,          64'h12345678,          0,    8'h0F, 64'h0,                 64'h12345678,          2,  1,  0, 2'b00};
        vecs[6]  = '{0, 1, 0, 3'b001, 32'h106, 64'h0,          64'h80017FFF,          0,    8'h0C, 64'h0,                 64'hFFFF8001,          2,  1,  0, 2'b00};
        vecs[7]  = '{0, 1, 0, 3'b101, 32'h106, 64'h0,          64'h80017FFF,          0,    8'h0C, 64'h0,                 64'h00008001,          2,  1,  0, 2'b00};
        vecs[8]  = '{0, 0, 1, 3'b000, 32'h101, 64'h000000A5,   64'h0,                 0,    8'h02, 64'hA5A5A5A5,          64'h00008001,          2,  1,  0, 2'b00};
        vecs[9]  = '{0, 0, 1, 3'b010, 32'h108, 64'hCAFEF00D,   64'h0,                 1,    8'h0F, 64'hCAFEF00D,          64'h00008001,          3,  2,  0, 2'b00};
        vecs[10] = '{0, 1, 0, 3'b011, 32'h108, 64'h0,          64'h0,                 0,    8'h00, 64'h0,                 64'h00008001,          1,  0,  1, 2'b11};
        vecs[11] = '{0, 0, 1, 3'b100, 32'h100, 64'h11,         64'h0,                 0,    8'h00, 64'h0,                 64'h00008001,          1,  0,  1, 2'b11};
        vecs[12] = '{0, 1, 1, 3'b010, 32'h100, 64'h0,          64'h0,                 0,    8'h00, 64'h0,                 64'h00008001,          1,  0,  1, 2'b11};
        vecs[13] = '{0, 1, 0, 3'b010, 32'h200, 64'h0,          64'h0,                 1000, 8'h0F, 64'h0,                 64'h00008001,          5,  4,  1, 2'b10};
        vecs[14] = '{0, 1, 0, 3'b010, 32'h204, 64'h0,          64'h00000001,          3,    8'h0F, 64'h0,                 64'h00000001,          5,  4,  0, 2'b00};
        vecs[15] = '{0, 0, 1, 3'b001, 32'h101, 64'h1234,       64'h0,                 0,    8'h00, 64'h0,                 64'h00000001,          1,  0,  1, 2'b01};
        vecs[16] = '{1, 1, 0, 3'b011, 32'h008, 64'h0,          64'h8123456789ABCDEF,  10,   8'hFF, 64'h0,                 64'h8123456789ABCDEF,  12, 11, 0, 2'b00};
        vecs[17] = '{1, 1, 0, 3'b010, 32'h00C, 64'h0,          64'h8000000011111111,  0,    8'hF0, 64'h0,                 64'hFFFFFFFF80000000,  2,  1,  0, 2'b00};
        vecs[18] = '{1, 1, 0, 3'b110, 32'h00C, 64'h0,          64'h8000000011111111,  0,    8'hF0, 64'h0,                 64'h0000000080000000,  2,  1,  0, 2'b00};
        vecs[19] = '{1, 0, 1, 3'b000, 32'h005, 64'h5A,         64'h0,                 0,    8'h20, 64'h5A5A5A5A5A5A5A5A,  64'h0000000080000000,  2,  1,  0, 2'b00};
        vecs[20] = '{1, 1, 0, 3'b011, 32'h004, 64'h0,          64'h0,                 0,    8'h00, 64'h0,                 64'h0000000080000000,  1,  0,  1, 2'b01};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset32 ctl", {b32.core_done, b32.core_fault, b32.fault_cause,
                            b32.bus_read_enable, b32.bus_write_enable}, 64'h0);
        chk("reset32 data", {b32.core_read_data, b32.bus_write_data}, 64'h0);
        chk("reset32 bus", {b32.bus_address, b32.bus_byte_enable}, 64'h0);
        chk("reset64 ctl", {b64.core_done, b64.core_fault, b64.fault_cause,
                            b64.bus_read_enable, b64.bus_write_enable}, 64'h0);
        chk("reset64 data", b64.core_read_data | b64.bus_write_data, 64'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Enables held through done start a new access; inputs changed
        // mid-access are ignored until then.
        b32.core_read_enable = 1'b1; b32.core_data_format = 3'b010;
        b32.core_address = 32'h100; b32.bus_read_data = 32'h11223344;
        @(negedge clock);
        chk("hold n1 strobe", b32.bus_read_enable, 1'b1);
        b32.bus_ready = 1'b1;
        b32.core_address = 32'h5555; b32.core_data_format = 3'b000;
        @(negedge clock);
        b32.bus_ready = 1'b0;
        chk("hold n2 done", b32.core_done, 1'b1);
        chk("hold n2 read_data", b32.core_read_data, 32'h11223344);
        chk("hold n2 addr", b32.bus_address, 32'h100);
        @(negedge clock);
        chk("hold n3 idle", {b32.bus_read_enable, b32.core_done}, 2'b00);
        @(negedge clock);
        chk("hold n4 strobe", b32.bus_read_enable, 1'b1);
        chk("hold n4 addr", b32.bus_address, 32'h5554);
        chk("hold n4 be", b32.bus_byte_enable, 4'b0010);
        b32.bus_ready = 1'b1;
        b32.core_read_enable = 1'b0;
        @(negedge clock);
        b32.bus_ready = 1'b0;
        chk("hold n5 done", b32.core_done, 1'b1);
        chk("hold n5 read_data", b32.core_read_data, 32'h00000033);
        @(negedge clock);

        // Reset in the middle of an access.
        b32.core_read_enable = 1'b1; b32.core_data_format = 3'b010;
        b32.core_address = 32'h300;
        @(negedge clock);
        @(negedge clock);
        chk("rst n2 strobe", b32.bus_read_enable, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst strobe low", {b32.bus_read_enable, b32.bus_write_enable, b32.core_done}, 3'b000);
        reset = 1'b0;
        idle_inputs();
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clock);
                if (b32.core_done || b32.bus_read_enable) seen++;
            end
            chk("rst no done", seen, 0);
        end
        chk("rst read_data", b32.core_read_data, 32'h0);
        run_vec(vecs[0], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
